// File: rtl/eth_pcs_rx_block_lock.sv
// eth_pcs_rx_block_lock
//   64b/66b receive block-lock engine. Checks the 2-bit sync header of each
//   block from the gearbox, declares and drops block lock, and pulses o_slip
//   so the gearbox walks its bit offset until headers line up.
//
//   Optional hi-BER monitor is compiled in with `define ETH_PCS_HI_BER_EN;
//   without it o_hi_ber is tied low and BER_WIN/BER_TH have no effect.
//
// Ports
//   i_clk         core clock
//   i_rst_n       synchronous reset, active low
//   i_valid       new 66b block this cycle, qualifies i_sync
//   i_sync        sync header of the current block
//   o_slip        one-cycle pulse: gearbox shifts its offset by one bit
//   o_block_lock  block lock achieved
//   o_hi_ber      high bit-error-rate flag
//
// state     | meaning
// LOCK_INIT | lock cleared, entered from reset
// RESET_CNT | clear window counters, no block consumed
// TEST_SH   | test one header per valid block, evaluate window
// SLIP      | slip issued on entry, then skip SLIP_HOLDOFF blocks

module eth_pcs_rx_block_lock #(
   parameter int W_SYNC       = 2,
   parameter int SH_VAL_TH    = 64,
   parameter int SH_INVAL_TH  = 16,
   parameter int SLIP_HOLDOFF = 2,
   parameter int BER_WIN      = 19531,
   parameter int BER_TH       = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   input  logic [W_SYNC-1:0] i_sync,
   output logic              o_slip,
   output logic              o_block_lock,
   output logic              o_hi_ber
);

   localparam int SH_W  = $clog2(SH_VAL_TH + 1);
   localparam int INV_W = $clog2(SH_INVAL_TH + 1);
   localparam int HO_W  = $clog2(SLIP_HOLDOFF + 1);

   localparam logic [SH_W-1:0]  SH_MAX  = SH_W'(SH_VAL_TH);
   localparam logic [INV_W-1:0] INV_MAX = INV_W'(SH_INVAL_TH);
   localparam logic [HO_W-1:0]  HO_LAST = HO_W'(SLIP_HOLDOFF - 1);

   typedef enum logic [1:0] {
      LOCK_INIT,
      RESET_CNT,
      TEST_SH,
      SLIP
   } state_t;

   state_t            state, state_nxt;
   logic [SH_W-1:0]   sh_cnt, sh_cnt_nxt;
   logic [INV_W-1:0]  invld_cnt, invld_cnt_nxt;
   logic [HO_W-1:0]   hold_cnt, hold_cnt_nxt;
   logic              lock_nxt;
   logic              slip_nxt;
   logic              sh_ok;

   assign sh_ok = (i_sync == W_SYNC'(2'b01)) || (i_sync == W_SYNC'(2'b10));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state        <= LOCK_INIT;
         sh_cnt       <= '0;
         invld_cnt    <= '0;
         hold_cnt     <= '0;
         o_block_lock <= 1'b0;
         o_slip       <= 1'b0;
      end else begin
         state        <= state_nxt;
         sh_cnt       <= sh_cnt_nxt;
         invld_cnt    <= invld_cnt_nxt;
         hold_cnt     <= hold_cnt_nxt;
         o_block_lock <= lock_nxt;
         o_slip       <= slip_nxt;
      end
   end

   // Window decisions look at the counts including the current block.
   always_comb begin
      state_nxt     = state;
      sh_cnt_nxt    = sh_cnt;
      invld_cnt_nxt = invld_cnt;
      hold_cnt_nxt  = hold_cnt;
      lock_nxt      = o_block_lock;
      slip_nxt      = 1'b0;
      case (state)
         LOCK_INIT: begin
            lock_nxt  = 1'b0;
            state_nxt = RESET_CNT;
         end
         RESET_CNT: begin
            sh_cnt_nxt    = '0;
            invld_cnt_nxt = '0;
            state_nxt     = TEST_SH;
         end
         TEST_SH: begin
            if (i_valid) begin
               if (sh_cnt != SH_MAX) begin
                  sh_cnt_nxt = sh_cnt + SH_W'(1);
               end
               if (!sh_ok && (invld_cnt != INV_MAX)) begin
                  invld_cnt_nxt = invld_cnt + INV_W'(1);
               end
               if (!sh_ok && (!o_block_lock || (invld_cnt_nxt == INV_MAX))) begin
                  state_nxt    = SLIP;
                  lock_nxt     = 1'b0;
                  slip_nxt     = 1'b1;
                  hold_cnt_nxt = '0;
               end else if (sh_cnt_nxt == SH_MAX) begin
                  if (invld_cnt_nxt == '0) begin
                     lock_nxt = 1'b1;
                  end
                  state_nxt = RESET_CNT;
               end
            end
         end
         SLIP: begin
            // Blocks here still carry the old offset; drop them while the gearbox settles.
            if (i_valid) begin
               if (hold_cnt == HO_LAST) begin
                  hold_cnt_nxt = '0;
                  state_nxt    = RESET_CNT;
               end else begin
                  hold_cnt_nxt = hold_cnt + HO_W'(1);
               end
            end
         end
         default: begin
            state_nxt = LOCK_INIT;
         end
      endcase
   end

`ifdef ETH_PCS_HI_BER_EN
   localparam int BW_W = $clog2(BER_WIN + 1);
   localparam int BC_W = $clog2(BER_TH + 1);

   localparam logic [BW_W-1:0] BW_MAX = BW_W'(BER_WIN);
   localparam logic [BC_W-1:0] BC_MAX = BC_W'(BER_TH);

   logic [BW_W-1:0] ber_win_cnt, ber_win_inc;
   logic [BC_W-1:0] ber_cnt, ber_inc;

   always_comb begin
      ber_win_inc = ber_win_cnt + BW_W'(1);
      ber_inc     = ber_cnt;
      if (!sh_ok && (ber_cnt != BC_MAX)) begin
         ber_inc = ber_cnt + BC_W'(1);
      end
   end

   // Counting starts with the first block after lock is visible; any loss
   // of lock (including the edge that drops it) wipes the window.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || !lock_nxt) begin
         ber_win_cnt <= '0;
         ber_cnt     <= '0;
         o_hi_ber    <= 1'b0;
      end else if (i_valid && o_block_lock) begin
         if (ber_win_inc == BW_MAX) begin
            ber_win_cnt <= '0;
            ber_cnt     <= '0;
            o_hi_ber    <= (ber_inc == BC_MAX);
         end else begin
            ber_win_cnt <= ber_win_inc;
            ber_cnt     <= ber_inc;
            if (ber_inc == BC_MAX) begin
               o_hi_ber <= 1'b1;
            end
         end
      end
   end
`else
   logic unused_ber_cfg;
   assign unused_ber_cfg = (BER_WIN > 0) && (BER_TH > 0);
   assign o_hi_ber       = 1'b0;
`endif

endmodule

// File: tb/tb_eth_pcs_rx_block_lock.sv
// Bench for eth_pcs_rx_block_lock. Each scenario task drives one block per
// clock, pushes the expected {o_slip, o_block_lock, o_hi_ber} for the edge
// that consumes it, then pops and compares after that edge.
module tb_eth_pcs_rx_block_lock;

`ifdef ETH_PCS_HI_BER_EN
   localparam bit HB_EN = 1'b1;
`else
   localparam bit HB_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid = 1'b0;
   logic [1:0] sync = 2'b01;
   logic       o_slip, o_block_lock, o_hi_ber;

   int         n_checks = 0;
   int         n_pass = 0;
   logic [2:0] exp_q[$];
   logic [2:0] got, e;

   always #5 clk = ~clk;

   eth_pcs_rx_block_lock #(
      .W_SYNC(2), .SH_VAL_TH(64), .SH_INVAL_TH(16), .SLIP_HOLDOFF(2),
      .BER_WIN(100), .BER_TH(4)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_sync(sync),
      .o_slip(o_slip), .o_block_lock(o_block_lock), .o_hi_ber(o_hi_ber)
   );

   task automatic drive(input logic r, input logic v, input logic [1:0] s);
      @(negedge clk);
      rst_n = r;
      valid = v;
      sync  = s;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] clean(input int i);
      return (i % 2 == 1) ? 2'b10 : 2'b01;
   endfunction

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 2'b11);
         exp_q.push_back(3'b000);
         tick();
         got = {o_slip, o_block_lock, o_hi_ber};
         e = exp_q.pop_front();
         n_checks++;
         if (got !== e) $display("FAIL reset[%0d] slip/lock/hi_ber got=%b expected=%b", i, got, e);
         else n_pass++;
      end
   endtask

   // Reset, then continuous clean headers: two cycles for LOCK_INIT/RESET_CNT,
   // lock visible right after the 64th tested block (step 65).
   task automatic acquire_lock(input string tag);
      drive(1'b0, 1'b0, 2'b01);
      exp_q.push_back(3'b000);
      tick();
      got = {o_slip, o_block_lock, o_hi_ber};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL %s_rst slip/lock/hi_ber got=%b expected=%b", tag, got, e);
      else n_pass++;
      for (int i = 0; i < 66; i++) begin
         drive(1'b1, 1'b1, clean(i));
         exp_q.push_back({1'b0, (i == 65), 1'b0});
         tick();
         got = {o_slip, o_block_lock, o_hi_ber};
         e = exp_q.pop_front();
         n_checks++;
         if (got !== e) $display("FAIL %s_acq[%0d] slip/lock/hi_ber got=%b expected=%b", tag, i, got, e);
         else n_pass++;
      end
   endtask

   task automatic test_clean_lock();
      acquire_lock("clean");
      for (int i = 0; i < 140; i++) begin
         drive(1'b1, 1'b1, clean(i));
         exp_q.push_back(3'b010);
         tick();
         got = {o_slip, o_block_lock, o_hi_ber};
         e = exp_q.pop_front();
         n_checks++;
         if (got !== e) $display("FAIL clean_hold[%0d] slip/lock/hi_ber got=%b expected=%b", i, got, e);
         else n_pass++;
      end
   endtask

   // Block k sits at step k+1. Block 10 (step 11) is 2'b11: slip after it,
   // steps 12-13 held off, step 14 RESET_CNT, steps 15..78 tested -> lock at 78.
   task automatic test_unlocked_slip();
      drive(1'b0, 1'b0, 2'b01);
      exp_q.push_back(3'b000);
      tick();
      got = {o_slip, o_block_lock, o_hi_ber};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL unlk_rst slip/lock/hi_ber got=%b expected=%b", got, e);
      else n_pass++;
      for (int i = 0; i < 86; i++) begin
         drive(1'b1, 1'b1, (i == 11) ? 2'b11 : clean(i));
         exp_q.push_back({(i == 11), (i >= 78), 1'b0});
         tick();
         got = {o_slip, o_block_lock, o_hi_ber};
         e = exp_q.pop_front();
         n_checks++;
         if (got !== e) $display("FAIL unlk_slip[%0d] slip/lock/hi_ber got=%b expected=%b", i, got, e);
         else n_pass++;
      end
   endtask

   task automatic test_locked_window();
      acquire_lock("win");
      for (int w = 0; w < 2; w++) begin
         drive(1'b1, 1'b0, 2'b11);
         exp_q.push_back(3'b010);
         tick();
         got = {o_slip, o_block_lock, o_hi_ber};
         e = exp_q.pop_front();
         n_checks++;
         if (got !== e) $display("FAIL win_gap[%0d] slip/lock/hi_ber got=%b expected=%b", w, got, e);
         else n_pass++;
         // Window 0: 15 invalid (b=0,4..56) tolerated. Window 1: 16th invalid at b=60 drops lock.
         for (int b = 0; b < ((w == 0) ? 64 : 61); b++) begin
            drive(1'b1, 1'b1, ((b % 4 == 0) && (b < 60 + 4 * w)) ? 2'b11 : clean(b));
            exp_q.push_back((w == 1 && b == 60) ? 3'b100 : 3'b010);
            tick();
            got = {o_slip, o_block_lock, o_hi_ber};
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL win%0d[%0d] slip/lock/hi_ber got=%b expected=%b", w, b, got, e);
            else n_pass++;
         end
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, clean(i));
         exp_q.push_back(3'b000);
         tick();
         got = {o_slip, o_block_lock, o_hi_ber};
         e = exp_q.pop_front();
         n_checks++;
         if (got !== e) $display("FAIL win_after[%0d] slip/lock/hi_ber got=%b expected=%b", i, got, e);
         else n_pass++;
      end
   endtask

   // Valid on odd steps only; idle steps carry 2'b11 which must be ignored.
   // The idle step after each 64th block lands on RESET_CNT, so windows align.
   task automatic test_toggle_valid();
      acquire_lock("tog");
      for (int w = 0; w < 10; w++) begin
         for (int j = 0; j < 128; j++) begin
            if (j % 2 == 0) drive(1'b1, 1'b0, 2'b11);
            else drive(1'b1, 1'b1, (((j / 2) % 4 == 0) && ((j / 2) < 60)) ? 2'b00 : clean(j / 2));
            exp_q.push_back(3'b010);
            tick();
            got = {o_slip, o_block_lock, o_hi_ber};
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL toggle_w%0d[%0d] slip/lock/hi_ber got=%b expected=%b", w, j, got, e);
            else n_pass++;
         end
      end
   endtask

   // BER window of 100 blocks starts at k=0. Invalid at k=10,20,30,40:
   // flag after k=40, kept through end of window 1, cleared after k=199.
   task automatic test_hi_ber();
      acquire_lock("ber");
      for (int k = 0; k < 220; k++) begin
         drive(1'b1, 1'b1, ((k % 10 == 0) && (k >= 10) && (k <= 40)) ? 2'b11 : clean(k));
         exp_q.push_back({1'b0, 1'b1, HB_EN && (k >= 40) && (k < 199)});
         tick();
         got = {o_slip, o_block_lock, o_hi_ber};
         e = exp_q.pop_front();
         n_checks++;
         if (got !== e) $display("FAIL hi_ber[%0d] slip/lock/hi_ber got=%b expected=%b", k, got, e);
         else n_pass++;
      end
   endtask

   task automatic test_reset_midop();
      // Slip after block 5 (step 6), reset at step 7 during holdoff.
      drive(1'b0, 1'b0, 2'b01);
      exp_q.push_back(3'b000);
      tick();
      got = {o_slip, o_block_lock, o_hi_ber};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL mid_rst slip/lock/hi_ber got=%b expected=%b", got, e);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         drive((i != 7), 1'b1, (i == 6) ? 2'b00 : clean(i));
         exp_q.push_back({(i == 6), 1'b0, 1'b0});
         tick();
         got = {o_slip, o_block_lock, o_hi_ber};
         e = exp_q.pop_front();
         n_checks++;
         if (got !== e) $display("FAIL mid_hold[%0d] slip/lock/hi_ber got=%b expected=%b", i, got, e);
         else n_pass++;
      end
      for (int i = 0; i < 66; i++) begin
         drive(1'b1, 1'b1, clean(i));
         exp_q.push_back({1'b0, (i == 65), 1'b0});
         tick();
         got = {o_slip, o_block_lock, o_hi_ber};
         e = exp_q.pop_front();
         n_checks++;
         if (got !== e) $display("FAIL mid_relock[%0d] slip/lock/hi_ber got=%b expected=%b", i, got, e);
         else n_pass++;
      end
      // Reset while locked, then an invalid header coinciding with reset
      // must not leave a slip pulse behind.
      for (int i = 0; i < 6; i++) begin
         drive((i != 0) && (i != 4), 1'b1, (i == 4 || i == 5) ? 2'b11 : clean(i));
         exp_q.push_back(3'b000);
         tick();
         got = {o_slip, o_block_lock, o_hi_ber};
         e = exp_q.pop_front();
         n_checks++;
         if (got !== e) $display("FAIL mid_lockrst[%0d] slip/lock/hi_ber got=%b expected=%b", i, got, e);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_clean_lock();
      test_unlocked_slip();
      test_locked_window();
      test_toggle_valid();
      test_hi_ber();
      test_reset_midop();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
